// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank read/check responder: state codes and
// the test-pattern arithmetic used by both the checker and the pattern writer.
package jtsdram_pkg;

    localparam int KEY_W = 5;
    localparam int PAT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Three full copies of the key plus its MSB fill the 16-bit seed.
    function automatic logic [PAT_W-1:0] key_fold(input logic [KEY_W-1:0] key);
        return {key, key, key, key[KEY_W-1]};
    endfunction

    function automatic logic [PAT_W-1:0] pat_exp(input logic [PAT_W-1:0] pat,
                                                 input logic [PAT_W-1:0] addr16);
        return pat + addr16;
    endfunction

endpackage

// File: rtl/jtsdram_bank_chk_if.sv
// Bank port between a read/check responder (master) and the SDRAM controller
// (slave): one outstanding read, request acknowledged, data returned later.
interface jtsdram_bank_chk_if #(
    parameter int AW = 22
);
    logic          ba_rd;
    logic [AW-1:0] ba_addr;
    logic          ba_ack;
    logic          ba_rdy;
    logic [15:0]   ba_dout;

    modport master (
        output ba_rd,
        output ba_addr,
        input  ba_ack,
        input  ba_rdy,
        input  ba_dout
    );

    modport slave (
        input  ba_rd,
        input  ba_addr,
        output ba_ack,
        output ba_rdy,
        output ba_dout
    );

endinterface

// File: rtl/jtsdram_chk_pat.sv
// Combinational expected-word generator; shared with the pattern programmer so
// written and checked data come from the same arithmetic.
module jtsdram_chk_pat
    import jtsdram_pkg::*;
#(
    parameter int AW = 22
) (
    input  logic [KEY_W-1:0] key_i,
    input  logic [PAT_W-1:0] data_ref_i,
    input  logic [AW-1:0]    addr_i,
    output logic [PAT_W-1:0] exp_o
);

    logic [PAT_W-1:0] pat_w;

    assign pat_w = data_ref_i ^ key_fold(key_i);
    // Narrow address buses are zero-extended, wide ones keep only the low 16 bits.
    assign exp_o = pat_exp(pat_w, PAT_W'(addr_i));

endmodule

// File: rtl/jtsdram_bank_chk.sv
// Per-bank read/check responder: reads COUNT words from one bank, compares each
// against the regenerated pattern and keeps sticky error/timeout status.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for rd_start; done holds its last value
// REQ     | ba_rd high for the current address, waiting for ack
// WAIT    | request accepted, waiting for rdy and read data
// DONE    | pass finished or aborted; raises done and returns to IDLE
module jtsdram_bank_chk
    import jtsdram_pkg::*;
#(
    parameter int AW    = 22,
    parameter int COUNT = 1024,
    parameter int TOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_start_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [PAT_W-1:0]  data_ref_i,
    output logic              done_o,
    jtsdram_bank_chk_if.master ba,
    output logic              err_o,
    output logic [7:0]        err_cnt_o,
    output logic [AW-1:0]     err_addr_o,
    output logic              tout_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(COUNT - 1);
    localparam logic [7:0]    TMR_LOAD  = 8'(TOUT);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [PAT_W-1:0] ref_q, ref_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [AW-1:0]    err_addr_q, err_addr_d;
    logic             tout_q, tout_d;

    logic [PAT_W-1:0] exp_w;
    logic             got_data;
    logic             mismatch;
    logic             last_addr;
    logic             tmr_expired;

    jtsdram_chk_pat #(
        .AW (AW)
    ) u_pat (
        .key_i      (key_q),
        .data_ref_i (ref_q),
        .addr_i     (addr_q),
        .exp_o      (exp_w)
    );

    // ack and rdy together in REQ count as an ack immediately followed by data.
    assign got_data    = ((state_q == ST_REQ) && ba.ba_ack && ba.ba_rdy) ||
                         ((state_q == ST_WAIT) && ba.ba_rdy);
    assign mismatch    = got_data && (ba.ba_dout != exp_w);
    assign last_addr   = (addr_q == LAST_ADDR);
    assign tmr_expired = (tmr_q <= 8'd1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        key_d      = key_q;
        ref_d      = ref_q;
        tmr_d      = tmr_q;
        done_d     = done_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        tout_d     = tout_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_start_i) begin
                    key_d   = key_i;
                    ref_d   = data_ref_i;
                    done_d  = 1'b0;
                    addr_d  = '0;
                    tmr_d   = TMR_LOAD;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (got_data) begin
                    tmr_d = TMR_LOAD;
                    if (last_addr) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = ST_REQ;
                    end
                end else if ((state_q == ST_REQ) && ba.ba_ack) begin
                    tmr_d   = TMR_LOAD;
                    state_d = ST_WAIT;
                end else if (tmr_expired) begin
                    tout_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (err_cnt_q == 8'd0) begin
                err_addr_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            key_q      <= '0;
            ref_q      <= '0;
            tmr_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            key_q      <= key_d;
            ref_q      <= ref_d;
            tmr_q      <= tmr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            tout_q     <= tout_d;
        end
    end

    assign ba.ba_rd    = (state_q == ST_REQ);
    assign ba.ba_addr  = addr_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_addr_o  = err_addr_q;
    assign tout_o      = tout_q;

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// Scoreboard bench for jtsdram_bank_chk: a 4-word instance exercises pass
// timing, errors, reset and timeout; a 300-word instance exercises saturation.
module tb_jtsdram_bank_chk;

    localparam int AW_A  = 22;
    localparam int CNT_A = 4;
    localparam int AW_B  = 12;
    localparam int CNT_B = 300;

    typedef struct packed {
        logic        err;
        logic [7:0]  cnt;
        logic [21:0] eaddr;
        logic        tout;
    } status_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd_start_a, done_a, err_a, tout_a;
    logic [4:0]  key_a;
    logic [15:0] ref_a;
    logic [7:0]  err_cnt_a;
    logic [21:0] err_addr_a;

    logic        rd_start_b, done_b, err_b, tout_b;
    logic [4:0]  key_b;
    logic [15:0] ref_b;
    logic [7:0]  err_cnt_b;
    logic [11:0] err_addr_b;

    jtsdram_bank_chk_if #(.AW(AW_A)) ifa ();
    jtsdram_bank_chk_if #(.AW(AW_B)) ifb ();

    jtsdram_bank_chk #(.AW(AW_A), .COUNT(CNT_A), .TOUT(255)) dut_a (
        .clk(clk), .rst(rst), .rd_start_i(rd_start_a), .key_i(key_a),
        .data_ref_i(ref_a), .done_o(done_a), .ba(ifa), .err_o(err_a),
        .err_cnt_o(err_cnt_a), .err_addr_o(err_addr_a), .tout_o(tout_a)
    );

    jtsdram_bank_chk #(.AW(AW_B), .COUNT(CNT_B), .TOUT(255)) dut_b (
        .clk(clk), .rst(rst), .rd_start_i(rd_start_b), .key_i(key_b),
        .data_ref_i(ref_b), .done_o(done_b), .ba(ifb), .err_o(err_b),
        .err_cnt_o(err_cnt_b), .err_addr_o(err_addr_b), .tout_o(tout_b)
    );

    // Hand-computed words for key 0x0A, ref 0xAAAA: pat = 0xAAAA ^ 0x5294 = 0xF83E.
    logic [15:0] mem_a [4] = '{16'hF83E, 16'hF83F, 16'hF840, 16'hF841};

    // Controller model A: mode 0 ack with rd, rdy rdy_dly_a cycles later;
    // mode 1 ack and rdy together; mode 2 never ack.
    int          mode_a    = 0;
    int          rdy_dly_a = 1;
    int          rdy_cnt_a = 0;
    int          bad_a     = -1;
    logic [21:0] lat_addr_a = '0;
    logic [21:0] dout_addr_a;

    assign ifa.ba_ack    = ifa.ba_rd && (mode_a != 2);
    assign ifa.ba_rdy    = (mode_a == 1) ? ifa.ba_rd : (rdy_cnt_a == 1);
    assign dout_addr_a   = (mode_a == 1) ? ifa.ba_addr : lat_addr_a;
    assign ifa.ba_dout   = (int'(dout_addr_a) == bad_a) ? 16'h0000 : mem_a[dout_addr_a[1:0]];

    always @(posedge clk) begin
        if (rdy_cnt_a > 0) rdy_cnt_a <= rdy_cnt_a - 1;
        if (mode_a == 0 && ifa.ba_rd && ifa.ba_ack) begin
            rdy_cnt_a  <= rdy_dly_a;
            lat_addr_a <= ifa.ba_addr;
        end
    end

    // Controller model B: zero-wait, every returned word deliberately wrong.
    localparam logic [4:0]  KEY_B = 5'h1F;
    localparam logic [15:0] REF_B = 16'h1234;
    int          rdy_cnt_b  = 0;
    logic [11:0] lat_addr_b = '0;

    function automatic logic [15:0] model_exp(input logic [4:0] k, input logic [15:0] r,
                                              input logic [11:0] a);
        logic [15:0] p;
        p = r ^ {k, k, k, k[4]};
        return p + {4'h0, a};
    endfunction

    assign ifb.ba_ack  = ifb.ba_rd;
    assign ifb.ba_rdy  = (rdy_cnt_b == 1);
    assign ifb.ba_dout = model_exp(KEY_B, REF_B, lat_addr_b) ^ 16'h8001;

    always @(posedge clk) begin
        if (rdy_cnt_b > 0) rdy_cnt_b <= rdy_cnt_b - 1;
        if (ifb.ba_rd && ifb.ba_ack) begin
            rdy_cnt_b  <= 1;
            lat_addr_b <= ifb.ba_addr;
        end
    end

    // Scoreboard
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [21:0] exp_addr_a [$];
    logic [21:0] exp_addr_b [$];
    status_t     exp_st_a [$];
    status_t     exp_st_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic empty_queue(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry queued", name);
    endtask

    task automatic cmp_status(input string tag, input status_t act, input status_t req);
        check({tag, "_err"},      32'(act.err),   32'(req.err));
        check({tag, "_err_cnt"},  32'(act.cnt),   32'(req.cnt));
        check({tag, "_err_addr"}, 32'(act.eaddr), 32'(req.eaddr));
        check({tag, "_tout"},     32'(act.tout),  32'(req.tout));
    endtask

    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;

    always @(negedge clk) begin
        if (ifa.ba_rd && ifa.ba_ack) begin
            if (exp_addr_a.size() == 0) empty_queue("a_req_addr");
            else check("a_req_addr", 32'(ifa.ba_addr), 32'(exp_addr_a.pop_front()));
        end
        if (done_a === 1'b1 && done_a_prev !== 1'b1) begin
            if (exp_st_a.size() == 0) empty_queue("a_status");
            else cmp_status("a_status", {err_a, err_cnt_a, err_addr_a, tout_a}, exp_st_a.pop_front());
        end
        done_a_prev <= done_a;
    end

    always @(negedge clk) begin
        if (ifb.ba_rd && ifb.ba_ack) begin
            if (exp_addr_b.size() == 0) empty_queue("b_req_addr");
            else check("b_req_addr", 32'(ifb.ba_addr), 32'(exp_addr_b.pop_front()));
        end
        if (done_b === 1'b1 && done_b_prev !== 1'b1) begin
            if (exp_st_b.size() == 0) empty_queue("b_status");
            else cmp_status("b_status", {err_b, err_cnt_b, 22'(err_addr_b), tout_b}, exp_st_b.pop_front());
        end
        done_b_prev <= done_b;
    end

    // Pulse rd_start; returns just after the edge that samples it (cycle 1).
    task automatic start_pass(input bit sel, input logic [4:0] k, input logic [15:0] r);
        @(negedge clk);
        if (sel) begin key_b = k; ref_b = r; rd_start_b = 1'b1; end
        else     begin key_a = k; ref_a = r; rd_start_a = 1'b1; end
        @(posedge clk);
        #1;
        rd_start_a = 1'b0;
        rd_start_b = 1'b0;
        @(negedge clk);
        check(sel ? "b_done_low" : "a_done_low", 32'(sel ? done_b : done_a), 32'd0);
    endtask

    // Cycles from the rd_start sampling edge until done is seen high; -1 on budget.
    task automatic wait_done(input bit sel, input int budget, output int cyc);
        cyc = -1;
        for (int i = 2; i <= budget; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((sel ? done_b : done_a) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_a(input int bad, input int lat, input status_t st, input string tag);
        int cyc;
        bad_a = bad;
        for (int i = 0; i < CNT_A; i++) exp_addr_a.push_back(22'(i));
        exp_st_a.push_back(st);
        start_pass(1'b0, 5'h0A, 16'hAAAA);
        wait_done(1'b0, 100, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int rd_hi;
        int addr_bad;
        bit found;

        rst = 1'b1;
        rd_start_a = 1'b0; key_a = '0; ref_a = '0;
        rd_start_b = 1'b0; key_b = '0; ref_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done",     32'(done_a),      32'd0);
        check("rst_ba_rd",    32'(ifa.ba_rd),   32'd0);
        check("rst_ba_addr",  32'(ifa.ba_addr), 32'd0);
        check("rst_err",      32'(err_a),       32'd0);
        check("rst_err_cnt",  32'(err_cnt_a),   32'd0);
        check("rst_err_addr", 32'(err_addr_a),  32'd0);
        check("rst_tout",     32'(tout_a),      32'd0);
        check("rst_b_done",   32'(done_b),      32'd0);
        rst = 1'b0;

        // Clean pass, then word 2 corrupted twice.
        run_a(-1, 10, '{err: 1'b0, cnt: 8'd0, eaddr: 22'd0, tout: 1'b0}, "a_clean");
        run_a(2,  10, '{err: 1'b1, cnt: 8'd1, eaddr: 22'd2, tout: 1'b0}, "a_bad2");
        run_a(2,  10, '{err: 1'b1, cnt: 8'd2, eaddr: 22'd2, tout: 1'b0}, "a_bad2_again");

        // Reset while waiting for data at address 1, with rdy still in flight.
        bad_a = -1;
        rdy_dly_a = 5;
        exp_addr_a.push_back(22'd0);
        exp_addr_a.push_back(22'd1);
        start_pass(1'b0, 5'h0A, 16'hAAAA);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ifa.ba_addr == 22'd1 && !ifa.ba_rd) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("a_reach_wait1", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("a_mid_rst_done",    32'(done_a),      32'd0);
        check("a_mid_rst_ba_rd",   32'(ifa.ba_rd),   32'd0);
        check("a_mid_rst_err_cnt", 32'(err_cnt_a),   32'd0);
        check("a_mid_rst_err",     32'(err_a),       32'd0);
        rd_hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifa.ba_rd || done_a || ifa.ba_addr != 22'd0) rd_hi++;
        end
        check("a_late_rdy_ignored", 32'(rd_hi), 32'd0);
        rdy_dly_a = 1;
        run_a(-1, 10, '{err: 1'b0, cnt: 8'd0, eaddr: 22'd0, tout: 1'b0}, "a_after_rst");

        // ack and rdy in the same cycle: one cycle per word.
        mode_a = 1;
        run_a(-1, 6, '{err: 1'b0, cnt: 8'd0, eaddr: 22'd0, tout: 1'b0}, "a_same_cycle");

        // Controller never acknowledges.
        mode_a = 2;
        exp_st_a.push_back('{err: 1'b0, cnt: 8'd0, eaddr: 22'd0, tout: 1'b1});
        start_pass(1'b0, 5'h0A, 16'hAAAA);
        rd_hi = 1;
        addr_bad = 0;
        cyc = -1;
        for (int i = 2; i <= 400; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifa.ba_rd) rd_hi++;
            if (ifa.ba_addr != 22'd0) addr_bad++;
            if (done_a) begin cyc = i; break; end
        end
        check("a_tout_rd_cycles", 32'(rd_hi),    32'd255);
        check("a_tout_addr_held", 32'(addr_bad), 32'd0);
        check("a_tout_latency",   32'(cyc),      32'd257);
        mode_a = 0;

        // Every word wrong over 300 reads: count saturates, first address kept.
        for (int i = 0; i < CNT_B; i++) exp_addr_b.push_back(22'(i));
        exp_st_b.push_back('{err: 1'b1, cnt: 8'd255, eaddr: 22'd0, tout: 1'b0});
        start_pass(1'b1, KEY_B, REF_B);
        wait_done(1'b1, 1000, cyc);
        check("b_latency", 32'(cyc), 32'd602);

        repeat (3) @(negedge clk);
        check("a_addr_queue_drained",   32'(exp_addr_a.size()), 32'd0);
        check("a_status_queue_drained", 32'(exp_st_a.size()),   32'd0);
        check("b_addr_queue_drained",   32'(exp_addr_b.size()), 32'd0);
        check("b_status_queue_drained", 32'(exp_st_b.size()),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
